// File: rtl/pwm4_pkg.sv
// pwm4_pkg: shared constants and types for the four-channel PWM driver.
//   NUM_CH    - number of PWM channels
//   DUTY_W    - width of one duty byte / period counter
//   CNT_MAX   - last period-counter value before the wrap (period = 255 ticks)
//   duty_t    - one channel's duty byte
//   duty_byte - extracts channel ch's byte from the 32-bit register word
package pwm4_pkg;

  localparam int NUM_CH = 4;
  localparam int DUTY_W = 8;
  localparam logic [DUTY_W-1:0] CNT_MAX = 8'd254;

  typedef logic [DUTY_W-1:0] duty_t;

  function automatic duty_t duty_byte(input logic [NUM_CH*DUTY_W-1:0] word, input int ch);
    return word[ch*DUTY_W +: DUTY_W];
  endfunction

endpackage

// File: rtl/pwm4_reg_driver_pwm_channel.sv
// pwm_channel: one PWM channel with a double-buffered duty (shadow) register
// and a registered compare output.
// Optional feature macro: PWM4_POLARITY_EN (adds the polarity input).
// Ports:
//   clk      - system clock
//   reset    - synchronous, active-high reset
//   load     - copy duty into the shadow register this cycle
//   enable   - channel running; output forced low when deasserted
//   pwm_cnt  - shared period counter
//   duty     - duty byte from the control register
//   polarity - (PWM4_POLARITY_EN only) invert the active level of the output
//   pwm      - registered PWM output
module pwm_channel
  import pwm4_pkg::*;
(
  input  logic  clk,
  input  logic  reset,
  input  logic  load,
  input  logic  enable,
  input  duty_t pwm_cnt,
  input  duty_t duty,
`ifdef PWM4_POLARITY_EN
  input  logic  polarity,
`endif
  output logic  pwm
);

  duty_t shadow_r;
  logic  pwm_r;
  logic  cmp_s;
  logic  pol_s;

`ifdef PWM4_POLARITY_EN
  assign pol_s = polarity;
`else
  assign pol_s = 1'b0;
`endif

  // Compare against the shadow value; a disabled channel is always low,
  // regardless of polarity.
  always_comb begin
    cmp_s = 1'b0;
    if (enable) begin
      cmp_s = (pwm_cnt < shadow_r) ^ pol_s;
    end else begin
      cmp_s = 1'b0;
    end
  end

  // Shadow register and output register; the shadow only changes on load so
  // a mid-period duty change cannot glitch the output.
  always_ff @(posedge clk) begin
    if (reset) begin
      shadow_r <= 8'd0;
      pwm_r    <= 1'b0;
    end else begin
      if (load) begin
        shadow_r <= duty;
      end
      pwm_r <= cmp_s;
    end
  end

  assign pwm = pwm_r;

endmodule

// File: rtl/pwm4_reg_driver.sv
// pwm4_reg_driver: four-channel 8-bit PWM generator driven by the 32-bit
// exported contents of a bus-writable control register. Byte i of duty_in is
// the duty of channel i; duty changes take effect at the next period boundary.
// Optional feature macro: PWM4_POLARITY_EN (adds the polarity input).
// Parameters:
//   PRESCALE - clk cycles per PWM tick (1..65535)
//   PRESC_W  - prescaler counter width, 2**PRESC_W >= PRESCALE
// Ports:
//   clk         - system clock
//   reset       - synchronous, active-high reset
//   duty_in     - duty bytes, [8i+7:8i] is channel i
//   enable      - run PWM; when low the block idles and shadows track duty_in
//   polarity    - (PWM4_POLARITY_EN only) per-channel output inversion
//   pwm_out     - registered PWM outputs
//   period_tick - one-cycle pulse at the start of each PWM period
module pwm4_reg_driver
  import pwm4_pkg::*;
#(
  parameter int PRESCALE = 50,
  parameter int PRESC_W  = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_CH*DUTY_W-1:0] duty_in,
  input  logic                     enable,
`ifdef PWM4_POLARITY_EN
  input  logic [NUM_CH-1:0]        polarity,
`endif
  output logic [NUM_CH-1:0]        pwm_out,
  output logic                     period_tick
);

  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(PRESCALE - 1);

  logic [PRESC_W-1:0] presc_cnt_r;
  duty_t              pwm_cnt_r;
  logic               period_tick_r;
  logic               tick_s;
  logic               wrap_s;
  logic               load_s;

  assign tick_s = enable && (presc_cnt_r == PRESC_LAST);
  assign wrap_s = tick_s && (pwm_cnt_r == CNT_MAX);
  // While idle the shadows follow duty_in, so enabling starts with the value
  // seen on the last disabled cycle.
  assign load_s = !enable || wrap_s;

  // Prescaler, period counter and the period-start pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      presc_cnt_r   <= PRESC_W'(0);
      pwm_cnt_r     <= 8'd0;
      period_tick_r <= 1'b0;
    end else if (!enable) begin
      presc_cnt_r   <= PRESC_W'(0);
      pwm_cnt_r     <= 8'd0;
      period_tick_r <= 1'b0;
    end else begin
      presc_cnt_r   <= tick_s ? PRESC_W'(0) : presc_cnt_r + PRESC_W'(1);
      if (tick_s) begin
        pwm_cnt_r <= wrap_s ? 8'd0 : pwm_cnt_r + 8'd1;
      end
      period_tick_r <= wrap_s;
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    pwm_channel u_ch (
      .clk     (clk),
      .reset   (reset),
      .load    (load_s),
      .enable  (enable),
      .pwm_cnt (pwm_cnt_r),
      .duty    (duty_byte(duty_in, i)),
`ifdef PWM4_POLARITY_EN
      .polarity(polarity[i]),
`endif
      .pwm     (pwm_out[i])
    );
  end

  assign period_tick = period_tick_r;

endmodule
